// File: rtl/calculation_unit_exponent_subtractor.sv
// Divide-path quotient exponent: (a - b) - norm_adjust over a 2-stage valid/ready pipe.
// Define EXPONENT_SATURATE_EN to clamp out-of-range results to the inf/zero codes.
module calculation_unit_exponent_subtractor #(
    parameter int EXP_WIDTH = 8,
    parameter int TAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_WIDTH-1:0]   aligned_exponent_a,
    input  logic [EXP_WIDTH-1:0]   aligned_exponent_b,
    input  logic                   norm_adjust,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_WIDTH+1:0]   exponent_diff,
    output logic                   exp_overflow,
    output logic                   exp_underflow,
    output logic [TAG_WIDTH-1:0]   out_tag
);
    localparam int DW = EXP_WIDTH + 2;
    localparam int HALF = 1 << (EXP_WIDTH - 1);

    localparam logic signed [DW-1:0] OVF_LIM = DW'(HALF - 1);
    localparam logic signed [DW-1:0] UNF_LIM = DW'(-(HALF - 2));
`ifdef EXPONENT_SATURATE_EN
    localparam logic signed [DW-1:0] SAT_HI = DW'(HALF);
    localparam logic signed [DW-1:0] SAT_LO = DW'(-(HALF - 1));
`endif

    logic                  r_s1_valid;
    logic signed [DW-1:0]  r_s1_diff;
    logic                  r_s1_adj;
    logic [TAG_WIDTH-1:0]  r_s1_tag;

    logic                  r_out_valid;
    logic [DW-1:0]         r_diff;
    logic                  r_ovf;
    logic                  r_unf;
    logic [TAG_WIDTH-1:0]  r_tag;

    logic                  w_s2_advance;
    logic                  w_accept;
    logic signed [DW-1:0]  w_s1_diff;
    logic signed [DW-1:0]  w_s2_raw;
    logic signed [DW-1:0]  w_s2_diff;
    logic                  w_ovf;
    logic                  w_unf;

    assign w_s2_advance = !r_out_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s2_advance;
    assign w_accept     = in_valid && in_ready;

    // Two guard bits: the full -255..+255 range cannot wrap.
    assign w_s1_diff = {{2{aligned_exponent_a[EXP_WIDTH-1]}}, aligned_exponent_a}
                     - {{2{aligned_exponent_b[EXP_WIDTH-1]}}, aligned_exponent_b};

    assign w_s2_raw = r_s1_diff - {{(DW-1){1'b0}}, r_s1_adj};
    assign w_ovf    = w_s2_raw > OVF_LIM;
    assign w_unf    = w_s2_raw < UNF_LIM;

    always_comb begin
        w_s2_diff = w_s2_raw;
`ifdef EXPONENT_SATURATE_EN
        if (w_ovf) begin
            w_s2_diff = SAT_HI;
        end else if (w_unf) begin
            w_s2_diff = SAT_LO;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_diff   <= '0;
            r_s1_adj    <= 1'b0;
            r_s1_tag    <= '0;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_tag       <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_diff <= w_s1_diff;
                r_s1_adj  <= norm_adjust;
                r_s1_tag  <= in_tag;
            end
            if (w_s2_advance) begin
                r_out_valid <= r_s1_valid;
                // Flags drop with out_valid so they never linger on an empty stage.
                if (r_s1_valid) begin
                    r_diff <= w_s2_diff;
                    r_ovf  <= w_ovf;
                    r_unf  <= w_unf;
                    r_tag  <= r_s1_tag;
                end else begin
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign exponent_diff = r_diff;
    assign exp_overflow  = r_ovf;
    assign exp_underflow = r_unf;
    assign out_tag       = r_tag;

endmodule

// File: tb/tb_calculation_unit_exponent_subtractor.sv
// Directed bench for calculation_unit_exponent_subtractor (default 8-bit exponents, 4-bit tags).
module tb_calculation_unit_exponent_subtractor;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       adj;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] diff;
    logic       ovf;
    logic       unf;
    logic [3:0] out_tag;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    calculation_unit_exponent_subtractor dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .aligned_exponent_a (exp_a),
        .aligned_exponent_b (exp_b),
        .norm_adjust        (adj),
        .in_tag             (in_tag),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .exponent_diff      (diff),
        .exp_overflow       (ovf),
        .exp_underflow      (unf),
        .out_tag            (out_tag)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One isolated op with out_ready=1; result expected two edges later.
    task automatic run_op(input string name, input logic [7:0] a,
                          input logic [7:0] b, input logic j,
                          input logic [3:0] t, input logic [9:0] e_diff,
                          input logic e_ovf, input logic e_unf);
        @(negedge clk);
        in_valid = 1'b1;
        exp_a = a;
        exp_b = b;
        adj = j;
        in_tag = t;
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, ".lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".diff"}, {22'd0, diff}, {22'd0, e_diff});
        chk({name, ".ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
        chk({name, ".unf"}, {31'd0, unf}, {31'd0, e_unf});
        chk({name, ".tag"}, {28'd0, out_tag}, {28'd0, t});
    endtask

    logic [9:0] q_diff[$];
    logic [3:0] q_tag[$];
    logic [9:0] h_diff;
    logic [3:0] h_tag;
    logic       held;
    logic       saw_full;
    int         sent;
    int         got_n;
    int         seen;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        exp_a = '0;
        exp_b = '0;
        adj = 1'b0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.diff", {22'd0, diff}, 32'd0);
        chk("rst.ovf", {31'd0, ovf}, 32'd0);
        chk("rst.unf", {31'd0, unf}, 32'd0);
        chk("rst.tag", {28'd0, out_tag}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        run_op("basic", 8'd10, 8'd3, 1'b0, 4'hA, 10'd7, 1'b0, 1'b0);
        run_op("neg", 8'hFB, 8'd4, 1'b1, 4'h5, 10'h3F6, 1'b0, 1'b0);
`ifdef EXPONENT_SATURATE_EN
        run_op("ovf", 8'd127, 8'h80, 1'b0, 4'h1, 10'h080, 1'b1, 1'b0);
        run_op("unf", 8'h82, 8'd1, 1'b1, 4'h2, 10'h381, 1'b0, 1'b1);
`else
        run_op("ovf", 8'd127, 8'h80, 1'b0, 4'h1, 10'h0FF, 1'b1, 1'b0);
        run_op("unf", 8'h82, 8'd1, 1'b1, 4'h2, 10'h380, 1'b0, 1'b1);
`endif
        run_op("max", 8'd127, 8'd0, 1'b0, 4'h3, 10'h07F, 1'b0, 1'b0);
        run_op("max+1", 8'd127, 8'hFF, 1'b0, 4'h4, 10'h080, 1'b1, 1'b0);
        run_op("min", 8'h82, 8'd0, 1'b0, 4'h6, 10'h382, 1'b0, 1'b0);
        run_op("min-1", 8'h82, 8'd0, 1'b1, 4'h7, 10'h381, 1'b0, 1'b1);

        // Back-to-back ops i=0..4: a=10i, b=i, adj=i&1 -> 9i-(i&1).
        for (int i = 0; i < 5; i++) begin
            q_diff.push_back(10'(9 * i - (i & 1)));
            q_tag.push_back(4'(i));
        end
        sent = 0;
        got_n = 0;
        held = 1'b0;
        saw_full = 1'b0;
        for (int c = 0; c < 40 && got_n < 5; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid = (sent < 5);
            exp_a = 8'(10 * sent);
            exp_b = 8'(sent);
            adj = sent[0];
            in_tag = 4'(sent);
            #1;
            if (held) begin
                chk("stall.diff", {22'd0, diff}, {22'd0, h_diff});
                chk("stall.tag", {28'd0, out_tag}, {28'd0, h_tag});
            end
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (in_valid && in_ready) sent++;
            held = out_valid && !out_ready;
            h_diff = diff;
            h_tag = out_tag;
            if (out_valid && out_ready) begin
                chk("b2b.diff", {22'd0, diff}, {22'd0, q_diff[got_n]});
                chk("b2b.tag", {28'd0, out_tag}, {28'd0, q_tag[got_n]});
                got_n++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("b2b.count", 32'(got_n), 32'd5);
        chk("b2b.full", {31'd0, saw_full}, 32'd1);

        // Two ops in flight, then reset.
        out_ready = 1'b0;
        in_valid = 1'b1;
        exp_a = 8'd20;
        exp_b = 8'd1;
        in_tag = 4'h9;
        @(negedge clk);
        in_tag = 4'hB;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid.valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid.stale", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
